mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the data (MEM-stage) port of the core.
- Grants at most one access per free cycle, tracks the single outstanding read, and returns read data to the port that issued it.
- Drives `fetch_stall` back to the fetch stage whenever a fetch request is not granted.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_WIDTH, 32, byte address width of both ports and the memory.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MEM_LATENCY, 1, cycles from `mem_en` (read) to valid `mem_rdata`; legal range 1..4.
- STARVE_LIMIT, 4, consecutive lost fetch arbitrations before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch read request; held until `if_gnt`.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  `if_rdata` valid.
- if_rdata  out  DATA_WIDTH  fetched word.
- d_req  in  1  data request; held until `d_gnt`.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  write data.
- d_be  in  DATA_WIDTH/8  write byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  `d_rdata` valid (reads only).
- d_rdata  out  DATA_WIDTH  loaded word.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_be  out  DATA_WIDTH/8  memory byte enables.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- fetch_stall  out  1  equals `if_req & ~if_gnt`.

Behaviour:
- States: IDLE, RD_WAIT.
- In IDLE, grant selection:
  - If `d_req` and `if_req` are both high: data wins unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
  - If only one request is high, that request wins.
- Grant outputs:
  - `if_gnt`/`d_gnt` are combinational, one-hot, high only in IDLE.
  - `mem_en` is high the same cycle as the grant; `mem_addr`/`mem_we`/`mem_be`/`mem_wdata` come from the winner.
  - Fetch grants always drive `mem_we=0`, `be=all ones`.
  - When nothing is granted, all mem outputs are 0.
- Write grant: completes in the grant cycle; no rvalid; state stays IDLE, so back-to-back writes run at one per cycle.
- Read grant:
  - Latch the source (IF/DATA) and go to RD_WAIT with `lat_cnt = MEM_LATENCY-1`.
  - Decrement `lat_cnt` each cycle; when it is 0, pulse the source's rvalid with rdata = `mem_rdata`, then return to IDLE next cycle.
  - Read throughput is one per MEM_LATENCY+1 cycles.
- In RD_WAIT: no grants; requests are ignored; `fetch_stall` follows `if_req`.
- rdata of the non-selected port is 0 (no leakage).
- `starve_cnt` (4 bits):
  - +1 when both request in IDLE and data wins; saturates at STARVE_LIMIT.
  - Cleared when fetch is granted.
  - Unchanged otherwise.
- Requests may change freely after their grant cycle.
- Reset:
  - All outputs 0, state IDLE, `starve_cnt` 0, `lat_cnt` 0.
  - Reset during RD_WAIT drops the pending rvalid; no rvalid is ever produced for a pre-reset grant.
- `rst` has priority over every other event in the same cycle.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Three 32-bit wrapping counters, cleared by `rst`, read on outputs `perf_if_grants`, `perf_d_grants`, `perf_conflicts`.
  - `perf_conflicts` counts IDLE cycles with both requests high.
- Undefined: these outputs exist and are tied to 0; no counter flops are synthesized.

Decomposition:
- Package `mem_arb_pkg`:
  - State encoding (`ARB_IDLE`, `ARB_RD_WAIT`).
  - Source encoding (`SRC_NONE`, `SRC_IF`, `SRC_DATA`).
  - Counter widths.
- Sub-module `mem_arb_starve_ctr`: saturating counter with inc/clr/limit-hit output.
- rvalid/source timing is built with the team's existing `delay` module where convenient.

Test Plan:
- Only `if_req`, addr 0x100, MEM_LATENCY=1: `if_gnt`+`mem_en` at cycle t; `if_rvalid` at t+1 with `mem_rdata` 0xDEADBEEF; next grant no earlier than t+2.
- Both requests continuously high, data reads, STARVE_LIMIT=4: data granted on 4 consecutive opportunities, fetch on the 5th, `starve_cnt` back to 0; `fetch_stall` high on every non-grant cycle.
- Data writes to 0x200/0x204/0x208 back-to-back: `d_gnt`, `mem_we` high on 3 consecutive cycles; no `d_rvalid`; `if_req` starved only until `starve_cnt` hits 4.
- MEM_LATENCY=3, data read: `d_rvalid` exactly 3 cycles after `d_gnt`; `if_req` raised mid-wait is not granted until the cycle after rvalid.
- `rst` asserted the cycle after a read grant: no rvalid ever; all outputs 0; the next request is granted normally.
- With MEM_ARB_PERF_EN defined, 10 conflict cycles at STARVE_LIMIT=1: `perf_conflicts`=10, and `perf_if_grants` and `perf_d_grants` alternate so that they differ by at most 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state/source encodings and counter widths for the unified-memory
// port arbiter.
package mem_arb_pkg;

   typedef enum logic {
      ARB_IDLE    = 1'b0,
      ARB_RD_WAIT = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_IF   = 2'd1,
      SRC_DATA = 2'd2
   } arb_src_e;

   localparam int STARVE_CNT_W = 4;
   localparam int LAT_CNT_W    = 2;
   localparam int PERF_CNT_W   = 32;

   // Down-counter load value so the last RD_WAIT cycle sees a count of zero.
   function automatic logic [LAT_CNT_W-1:0] lat_load(input int unsigned latency);
      return LAT_CNT_W'(latency - 32'd1);
   endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of fetch arbitrations lost to the data port; limit_hit
// tells the arbiter to hand the next conflict to fetch.
module mem_arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic limit_hit
);

   logic [STARVE_CNT_W-1:0] cnt_r;

   assign limit_hit = (cnt_r == STARVE_CNT_W'(LIMIT));

   // Clear wins over increment; the count never passes LIMIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {STARVE_CNT_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {STARVE_CNT_W{1'b0}};
      end else if (inc && !limit_hit) begin
         cnt_r <= cnt_r + STARVE_CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports; data has
// priority, fetch is protected by a starvation counter.
// Define MEM_ARB_PERF_EN to build the grant/conflict performance counters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_gnt,
   output logic                    if_rvalid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    fetch_stall,
   output logic [PERF_CNT_W-1:0]   perf_if_grants,
   output logic [PERF_CNT_W-1:0]   perf_d_grants,
   output logic [PERF_CNT_W-1:0]   perf_conflicts
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load(MEM_LATENCY);

   arb_state_e             state_r;
   arb_src_e               src_r;
   logic [LAT_CNT_W-1:0]   lat_cnt_r;

   logic idle_s;
   logic both_s;
   logic gnt_if_s;
   logic gnt_d_s;
   logic limit_hit_s;
   logic starve_inc_s;
   logic rd_done_s;

   // Grant selection; reset and an outstanding read both suppress grants
   always_comb begin
      idle_s   = (state_r == ARB_IDLE) && !rst;
      both_s   = if_req && d_req;
      gnt_if_s = 1'b0;
      gnt_d_s  = 1'b0;
      if (idle_s) begin
         if (d_req && !(if_req && limit_hit_s)) begin
            gnt_d_s = 1'b1;
         end else if (if_req) begin
            gnt_if_s = 1'b1;
         end else begin
            gnt_if_s = 1'b0;
            gnt_d_s  = 1'b0;
         end
      end else begin
         gnt_if_s = 1'b0;
         gnt_d_s  = 1'b0;
      end
      starve_inc_s = idle_s && both_s && gnt_d_s;
   end

   mem_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk       (clk),
      .rst       (rst),
      .inc       (starve_inc_s),
      .clr       (gnt_if_s),
      .limit_hit (limit_hit_s)
   );

   assign if_gnt      = gnt_if_s;
   assign d_gnt       = gnt_d_s;
   assign fetch_stall = if_req && !gnt_if_s && !rst;

   // Memory request mux: winner's fields, all zero when nothing is granted
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = {BE_W{1'b0}};
      mem_addr  = {ADDR_WIDTH{1'b0}};
      mem_wdata = {DATA_WIDTH{1'b0}};
      if (gnt_if_s) begin
         mem_en   = 1'b1;
         mem_be   = {BE_W{1'b1}};
         mem_addr = if_addr;
      end else if (gnt_d_s) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_be    = d_be;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else begin
         mem_en = 1'b0;
      end
   end

   // Read return steered to the issuing port; the other port reads zero
   always_comb begin
      rd_done_s = (state_r == ARB_RD_WAIT) && (lat_cnt_r == {LAT_CNT_W{1'b0}}) && !rst;
      if_rvalid = rd_done_s && (src_r == SRC_IF);
      d_rvalid  = rd_done_s && (src_r == SRC_DATA);
      if (if_rvalid) begin
         if_rdata = mem_rdata;
      end else begin
         if_rdata = {DATA_WIDTH{1'b0}};
      end
      if (d_rvalid) begin
         d_rdata = mem_rdata;
      end else begin
         d_rdata = {DATA_WIDTH{1'b0}};
      end
   end

   // Outstanding-read tracker: latches source and counts down memory latency
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ARB_IDLE;
         src_r     <= SRC_NONE;
         lat_cnt_r <= {LAT_CNT_W{1'b0}};
      end else begin
         case (state_r)
            ARB_IDLE: begin
               if (gnt_if_s) begin
                  state_r   <= ARB_RD_WAIT;
                  src_r     <= SRC_IF;
                  lat_cnt_r <= LAT_LOAD;
               end else if (gnt_d_s && !d_we) begin
                  state_r   <= ARB_RD_WAIT;
                  src_r     <= SRC_DATA;
                  lat_cnt_r <= LAT_LOAD;
               end else begin
                  state_r   <= ARB_IDLE;
                  src_r     <= SRC_NONE;
                  lat_cnt_r <= {LAT_CNT_W{1'b0}};
               end
            end
            ARB_RD_WAIT: begin
               if (lat_cnt_r == {LAT_CNT_W{1'b0}}) begin
                  state_r <= ARB_IDLE;
                  src_r   <= SRC_NONE;
               end else begin
                  lat_cnt_r <= lat_cnt_r - LAT_CNT_W'(1);
               end
            end
            default: begin
               state_r   <= ARB_IDLE;
               src_r     <= SRC_NONE;
               lat_cnt_r <= {LAT_CNT_W{1'b0}};
            end
         endcase
      end
   end

`ifdef MEM_ARB_PERF_EN
   logic [PERF_CNT_W-1:0] perf_if_r;
   logic [PERF_CNT_W-1:0] perf_d_r;
   logic [PERF_CNT_W-1:0] perf_conf_r;

   // Wrapping grant and conflict counters
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_if_r   <= {PERF_CNT_W{1'b0}};
         perf_d_r    <= {PERF_CNT_W{1'b0}};
         perf_conf_r <= {PERF_CNT_W{1'b0}};
      end else begin
         if (gnt_if_s) begin
            perf_if_r <= perf_if_r + PERF_CNT_W'(1);
         end else begin
            perf_if_r <= perf_if_r;
         end
         if (gnt_d_s) begin
            perf_d_r <= perf_d_r + PERF_CNT_W'(1);
         end else begin
            perf_d_r <= perf_d_r;
         end
         if (idle_s && both_s) begin
            perf_conf_r <= perf_conf_r + PERF_CNT_W'(1);
         end else begin
            perf_conf_r <= perf_conf_r;
         end
      end
   end

   assign perf_if_grants = perf_if_r;
   assign perf_d_grants  = perf_d_r;
   assign perf_conflicts = perf_conf_r;
`else
   assign perf_if_grants = {PERF_CNT_W{1'b0}};
   assign perf_d_grants  = {PERF_CNT_W{1'b0}};
   assign perf_conflicts = {PERF_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a cycle model predicts grants and
// queues expected read returns, which are popped when they fall due.
module tb_mem_port_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = 4;
   localparam int LAT   = 3;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_gnt, d_rvalid;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [BW-1:0] d_be;
   logic          mem_en, mem_we;
   logic [BW-1:0] mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          fetch_stall;
   logic [31:0]   perf_if_grants, perf_d_grants, perf_conflicts;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fetch_stall(fetch_stall),
      .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants), .perf_conflicts(perf_conflicts)
   );

   typedef struct { logic is_if; logic [DW-1:0] data; int due; } exp_t;
   typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BW-1:0] be; } dtx_t;
   typedef struct { int src; int cyc; } gnt_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] init_word(input int i);
      if (i == 64) return 32'hDEADBEEF;
      return {16'hC0DE, 8'h00, 8'(i)};
   endfunction

   // Environment memory: byte-enabled writes, reads returned LAT cycles after mem_en
   logic [DW-1:0] env_mem [256];
   logic          pipe_v  [LAT];
   logic [7:0]    pipe_a  [LAT];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
         for (int k = 0; k < LAT; k++) pipe_v[k] <= 1'b0;
      end else begin
         if (mem_en && mem_we)
            for (int b = 0; b < BW; b++)
               if (mem_be[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         pipe_v[0] <= mem_en && !mem_we;
         pipe_a[0] <= mem_addr[9:2];
         for (int k = 1; k < LAT; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_a[k] <= pipe_a[k-1];
         end
      end
   end

   assign mem_rdata = pipe_v[LAT-1] ? env_mem[pipe_a[LAT-1]] : 32'h0;

   logic [AW-1:0] if_q[$];
   dtx_t          d_q[$];
   exp_t          sb[$];
   gnt_t          glog[$];
   logic [DW-1:0] ref_mem [256];
   int            cyc = 0, m_busy = 0, m_starve = 0, rv_count = 0, last_drv_cyc = 0;
   logic [DW-1:0] last_if_rdata = 32'h0;
   logic [31:0]   e_pif = 32'h0, e_pd = 32'h0, e_pc = 32'h0;

   function automatic int g_src(input int k);
      return (k < glog.size()) ? glog[k].src : -1;
   endfunction

   function automatic int g_cyc(input int k);
      return (k < glog.size()) ? glog[k].cyc : -1000;
   endfunction

   // Fetch agent: holds each request until granted
   initial begin : if_agent
      logic seen;
      if_req  = 1'b0;
      if_addr = 32'h0;
      forever begin
         @(negedge clk);
         seen = if_req && if_gnt;
         @(posedge clk);
         #1;
         if (seen || !if_req) begin
            if (if_q.size() > 0) begin
               if_addr = if_q.pop_front();
               if_req  = 1'b1;
            end else begin
               if_req  = 1'b0;
            end
         end
      end
   end

   // Data agent: holds each request until granted
   initial begin : d_agent
      logic seen;
      dtx_t t;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
      forever begin
         @(negedge clk);
         seen = d_req && d_gnt;
         @(posedge clk);
         #1;
         if (seen || !d_req) begin
            if (d_q.size() > 0) begin
               t = d_q.pop_front();
               d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_be = t.be;
            end else begin
               d_req = 1'b0; d_we = 1'b0;
            end
         end
      end
   end

   // Cycle model and scoreboard, sampled on the falling edge
   initial begin : monitor
      exp_t          e;
      gnt_t          g;
      logic          egi, egd, eiv, edv;
      logic [DW-1:0] edata;
      forever begin
         @(negedge clk);
         cyc++;
         egi = 1'b0; egd = 1'b0; eiv = 1'b0; edv = 1'b0; edata = 32'h0;
         if (if_gnt || d_gnt) begin
            g.src = if_gnt ? 1 : 2;
            g.cyc = cyc;
            glog.push_back(g);
         end
         if (if_rvalid || d_rvalid) begin
            rv_count++;
            if (if_rvalid) last_if_rdata = if_rdata;
            if (d_rvalid)  last_drv_cyc  = cyc;
         end
         if (rst) begin
            chk("rst_ctrl", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, fetch_stall}, 64'h0);
            chk("rst_data", mem_addr | mem_wdata | if_rdata | d_rdata | {28'h0, mem_be}, 64'h0);
            m_busy = 0; m_starve = 0;
            sb.delete();
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            e_pif = 32'h0; e_pd = 32'h0; e_pc = 32'h0;
         end else begin
`ifdef MEM_ARB_PERF_EN
            chk("perf_if", perf_if_grants, e_pif);
            chk("perf_d", perf_d_grants, e_pd);
            chk("perf_conf", perf_conflicts, e_pc);
`else
            chk("perf_off", perf_if_grants | perf_d_grants | perf_conflicts, 64'h0);
`endif
            if (m_busy > 0) begin
               m_busy--;
            end else begin
               if (d_req && if_req) begin
                  e_pc++;
                  if (m_starve == LIMIT) egi = 1'b1;
                  else begin egd = 1'b1; m_starve++; end
               end else if (d_req) egd = 1'b1;
               else if (if_req)   egi = 1'b1;
               if (egi) begin
                  m_starve = 0;
                  e_pif++;
               end
               if (egd) e_pd++;
               if (egi || (egd && !d_we)) begin
                  m_busy  = LAT;
                  e.is_if = egi;
                  e.data  = egi ? ref_mem[if_addr[9:2]] : ref_mem[d_addr[9:2]];
                  e.due   = cyc + LAT;
                  sb.push_back(e);
               end
               if (egd && d_we)
                  for (int b = 0; b < BW; b++)
                     if (d_be[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
               e = sb.pop_front();
               eiv = e.is_if; edv = !e.is_if; edata = e.data;
            end
            chk("if_gnt", if_gnt, egi);
            chk("d_gnt", d_gnt, egd);
            chk("fetch_stall", fetch_stall, if_req && !egi);
            chk("mem_en", mem_en, egi || egd);
            chk("mem_we", mem_we, egd && d_we);
            chk("mem_be", mem_be, egi ? 4'hF : (egd ? d_be : 4'h0));
            chk("mem_addr", mem_addr, egi ? if_addr : (egd ? d_addr : 32'h0));
            chk("mem_wdata", mem_wdata, egd ? d_wdata : 32'h0);
            chk("if_rvalid", if_rvalid, eiv);
            chk("d_rvalid", d_rvalid, edv);
            chk("if_rdata", if_rdata, eiv ? edata : 32'h0);
            chk("d_rdata", d_rdata, edv ? edata : 32'h0);
         end
      end
   end

   task automatic drain();
      int n = 0;
      while (!(if_q.size() == 0 && d_q.size() == 0 && !if_req && !d_req &&
               sb.size() == 0 && m_busy == 0) && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain_timeout", n >= 1000, 1'b0);
   endtask

   task automatic wait_grants(input int cnt);
      int n = 0;
      while (glog.size() < cnt && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("grant_timeout", glog.size() < cnt, 1'b0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      dtx_t t;
      int   rv0;
      int   seq2 [12] = '{2, 2, 2, 2, 1, 2, 2, 1, 1, 1, 1, 1};
      int   seq3 [8]  = '{2, 2, 2, 2, 1, 2, 2, 1};
      logic [BW-1:0] wbe [6] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'hF, 4'h8};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Lone fetches: read latency and read-to-read spacing
      glog.delete();
      if_q.push_back(32'h100);
      if_q.push_back(32'h104);
      drain();
      chk("lone_cnt", glog.size(), 2);
      chk("lone_src", g_src(0), 1);
      chk("lone_spacing", g_cyc(1) - g_cyc(0), LAT + 1);
      chk("lone_data", last_if_rdata, 32'h0000_0000_C0DE0041);

      // Continuous conflict with data reads: four data wins, then fetch
      glog.delete();
      for (int k = 0; k < 6; k++) begin
         t = '{1'b0, 32'h10 + 32'(4 * k), 32'h0, 4'hF};
         d_q.push_back(t);
         if_q.push_back(32'h40 + 32'(4 * k));
      end
      drain();
      chk("conf_cnt", glog.size(), 12);
      for (int k = 0; k < 12; k++) chk("conf_order", g_src(k), seq2[k]);

      // Back-to-back writes against a waiting fetch
      glog.delete();
      for (int k = 0; k < 6; k++) begin
         t = '{1'b1, 32'h200 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), wbe[k]};
         d_q.push_back(t);
      end
      if_q.push_back(32'h100);
      if_q.push_back(32'h108);
      drain();
      chk("wr_cnt", glog.size(), 8);
      for (int k = 0; k < 8; k++) chk("wr_order", g_src(k), seq3[k]);
      for (int k = 1; k < 4; k++) chk("wr_b2b", g_cyc(k) - g_cyc(0), k);
      for (int k = 0; k < 6; k++) begin
         t = '{1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'hF};
         d_q.push_back(t);
      end
      drain();

      // Fetch raised during an outstanding data read
      glog.delete();
      t = '{1'b0, 32'h300, 32'h0, 4'hF};
      d_q.push_back(t);
      wait_grants(1);
      if_q.push_back(32'h10C);
      drain();
      chk("mid_src", g_src(1), 1);
      chk("mid_if_gnt", g_cyc(1) - g_cyc(0), LAT + 1);
      chk("mid_rvalid", last_drv_cyc - g_cyc(0), LAT);

      // Reset the cycle after a read grant drops its return
      glog.delete();
      t = '{1'b0, 32'h104, 32'h0, 4'hF};
      d_q.push_back(t);
      wait_grants(1);
      rv0 = rv_count;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (LAT + 3) @(negedge clk);
      #1;
      chk("rst_no_rvalid", rv_count, rv0);
      t = '{1'b0, 32'h108, 32'h0, 4'hF};
      d_q.push_back(t);
      drain();
      chk("rst_regrant", glog.size(), 2);
      chk("rst_regrant_rv", rv_count, rv0 + 1);

      // Random mixed traffic on both ports
      for (int k = 0; k < 40; k++) begin
         if_q.push_back({22'h0, 8'($urandom_range(0, 255)), 2'b00});
         t.we    = 1'($urandom_range(0, 1));
         t.addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         t.wdata = $urandom;
         t.be    = 4'($urandom_range(1, 15));
         d_q.push_back(t);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
